cmd_registry: RTL and testbench

Real-time command registry feeding the burst sequencer. Buffers burst commands (DDS frequency/chirp parameters, start time, impulse count/type, interval timers) written by the host-side parser and delivers them one at a time on the sequencer's `WR_DATA`/`MEM_*` load interface. It is the responder to the sequencer's `REQ_COMMAND` request. It discards commands whose start time can no longer be met.

---
 rtl/cmd_registry.sv | 165 ++++++++++++++++
 tb/tb_cmd_registry.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_registry.sv
// Command registry: buffers host burst commands and hands them one at a time to the
// burst sequencer, discarding any whose start time can no longer be met.
module cmd_registry #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LEAD  = 48
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     HOST_WR,
  input  logic [47:0]              HOST_DDS_freq,
  input  logic [47:0]              HOST_DDS_delta_freq,
  input  logic [31:0]              HOST_DDS_delta_rate,
  input  logic [63:0]              HOST_TIME_START,
  input  logic [15:0]              HOST_N_impuls,
  input  logic [1:0]               HOST_TYPE_impulse,
  input  logic [31:0]              HOST_Interval_Ti,
  input  logic [31:0]              HOST_Interval_Tp,
  input  logic [31:0]              HOST_Tblank1,
  input  logic [31:0]              HOST_Tblank2,
  input  logic                     FLUSH,
  input  logic [63:0]              TIME,
  input  logic                     REQ_COMMAND,
  output logic                     WR_DATA,
  output logic [47:0]              MEM_DDS_freq,
  output logic [47:0]              MEM_DDS_delta_freq,
  output logic [31:0]              MEM_DDS_delta_rate,
  output logic [63:0]              MEM_TIME_START,
  output logic [15:0]              MEM_N_impuls,
  output logic [1:0]               MEM_TYPE_impulse,
  output logic [31:0]              MEM_Interval_Ti,
  output logic [31:0]              MEM_Interval_Tp,
  output logic [31:0]              MEM_Tblank1,
  output logic [31:0]              MEM_Tblank2,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     LOADED,
  output logic                     OVERFLOW,
  output logic [15:0]              DROPPED
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] delta_freq;
    logic [31:0] delta_rate;
    logic [63:0] time_start;
    logic [15:0] n_impuls;
    logic [1:0]  type_impulse;
    logic [31:0] interval_ti;
    logic [31:0] interval_tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StCheck, StWait} state_e;

  cmd_t        mem_q [DEPTH];
  cmd_t        host_cmd, head, out_q, out_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e      state_q, state_d;
  logic        loaded_q, loaded_d, wr_data_q, wr_data_d, overflow_q, overflow_d, req_q;
  logic [15:0] dropped_q, dropped_d;
  logic        full, empty, push, pop, stale;

  assign host_cmd = {HOST_DDS_freq, HOST_DDS_delta_freq, HOST_DDS_delta_rate, HOST_TIME_START,
                     HOST_N_impuls, HOST_TYPE_impulse, HOST_Interval_Ti, HOST_Interval_Tp,
                     HOST_Tblank1, HOST_Tblank2};

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = HOST_WR & ~full & ~FLUSH;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  // Sum wraps modulo 2^64 by construction of the 64-bit add.
  assign stale = head.time_start < (TIME + 64'(LEAD));

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    wr_data_d = 1'b0;
    loaded_d  = loaded_q;
    out_d     = out_q;
    dropped_d = dropped_q;
    case (state_q)
      StIdle: begin
        // Only deliver while the sequencer sits in its start state.
        if (!loaded_q && !REQ_COMMAND && !empty && !FLUSH) state_d = StCheck;
      end
      StCheck: begin
        if (FLUSH) begin
          state_d = StIdle;
        end else if (stale) begin
          pop     = 1'b1;
          state_d = StIdle;
          if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
        end else begin
          pop       = 1'b1;
          out_d     = head;
          wr_data_d = 1'b1;
          loaded_d  = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (!req_q && REQ_COMMAND) begin
          loaded_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_ptr_d   = wr_ptr_q + (AW + 1)'(push);
  assign rd_ptr_d   = FLUSH ? wr_ptr_q : rd_ptr_q + (AW + 1)'(pop);
  assign overflow_d = overflow_q | (HOST_WR & full & ~FLUSH);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_q      <= '0;
      wr_data_q  <= 1'b0;
      loaded_q   <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_q      <= out_d;
      wr_data_q  <= wr_data_d;
      loaded_q   <= loaded_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
      req_q      <= REQ_COMMAND;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= host_cmd;
  end

  assign WR_DATA            = wr_data_q;
  assign MEM_DDS_freq       = out_q.freq;
  assign MEM_DDS_delta_freq = out_q.delta_freq;
  assign MEM_DDS_delta_rate = out_q.delta_rate;
  assign MEM_TIME_START     = out_q.time_start;
  assign MEM_N_impuls       = out_q.n_impuls;
  assign MEM_TYPE_impulse   = out_q.type_impulse;
  assign MEM_Interval_Ti    = out_q.interval_ti;
  assign MEM_Interval_Tp    = out_q.interval_tp;
  assign MEM_Tblank1        = out_q.tblank1;
  assign MEM_Tblank2        = out_q.tblank2;
  assign COUNT              = wr_ptr_q - rd_ptr_q;
  assign FULL               = full;
  assign EMPTY              = empty;
  assign LOADED             = loaded_q;
  assign OVERFLOW           = overflow_q;
  assign DROPPED            = dropped_q;

endmodule

// File: tb/tb_cmd_registry.sv
// Bench for cmd_registry: directed scenarios plus a randomized phase checked against a
// queue model of which commands must reach the sequencer and which must be dropped.
module tb_cmd_registry;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LEAD  = 48;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] delta_freq;
    logic [31:0] delta_rate;
    logic [63:0] time_start;
    logic [15:0] n_impuls;
    logic [1:0]  type_impulse;
    logic [31:0] interval_ti;
    logic [31:0] interval_tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_t;

  logic        CLK = 1'b0, RESET = 1'b1, HOST_WR = 1'b0, FLUSH = 1'b0, REQ_COMMAND = 1'b0;
  logic [63:0] tnow = 64'h0000_0001_0000_0000;
  cmd_t        host = '0;
  cmd_t        mem_obs;
  logic        WR_DATA, FULL, EMPTY, LOADED, OVERFLOW;
  logic [47:0] m_freq, m_dfreq;
  logic [31:0] m_drate, m_ti, m_tp, m_tb1, m_tb2;
  logic [63:0] m_ts;
  logic [15:0] m_n, DROPPED;
  logic [1:0]  m_type;
  logic [4:0]  COUNT;

  int   total = 0, bad = 0, strobes = 0;
  cmd_t cap_q[$];
  cmd_t exp_q[$];

  cmd_registry #(.DEPTH(DEPTH), .LEAD(LEAD)) dut (
    .CLK(CLK), .RESET(RESET), .HOST_WR(HOST_WR),
    .HOST_DDS_freq(host.freq), .HOST_DDS_delta_freq(host.delta_freq),
    .HOST_DDS_delta_rate(host.delta_rate), .HOST_TIME_START(host.time_start),
    .HOST_N_impuls(host.n_impuls), .HOST_TYPE_impulse(host.type_impulse),
    .HOST_Interval_Ti(host.interval_ti), .HOST_Interval_Tp(host.interval_tp),
    .HOST_Tblank1(host.tblank1), .HOST_Tblank2(host.tblank2),
    .FLUSH(FLUSH), .TIME(tnow), .REQ_COMMAND(REQ_COMMAND), .WR_DATA(WR_DATA),
    .MEM_DDS_freq(m_freq), .MEM_DDS_delta_freq(m_dfreq), .MEM_DDS_delta_rate(m_drate),
    .MEM_TIME_START(m_ts), .MEM_N_impuls(m_n), .MEM_TYPE_impulse(m_type),
    .MEM_Interval_Ti(m_ti), .MEM_Interval_Tp(m_tp), .MEM_Tblank1(m_tb1),
    .MEM_Tblank2(m_tb2), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .LOADED(LOADED),
    .OVERFLOW(OVERFLOW), .DROPPED(DROPPED)
  );

  assign mem_obs = {m_freq, m_dfreq, m_drate, m_ts, m_n, m_type, m_ti, m_tp, m_tb1, m_tb2};

  always #5 CLK = ~CLK;

  // Record every delivered command mid-cycle.
  always @(negedge CLK) begin
    if (WR_DATA === 1'b1) begin
      strobes++;
      cap_q.push_back(mem_obs);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmd(input string tag, input cmd_t obs, input cmd_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t rand_cmd(input logic [63:0] ts);
    cmd_t c;
    c.freq         = 48'({$urandom(), $urandom()});
    c.delta_freq   = 48'({$urandom(), $urandom()});
    c.delta_rate   = $urandom();
    c.time_start   = ts;
    c.n_impuls     = 16'($urandom());
    c.type_impulse = 2'($urandom());
    c.interval_ti  = $urandom();
    c.interval_tp  = $urandom();
    c.tblank1      = $urandom();
    c.tblank2      = $urandom();
    return c;
  endfunction

  task automatic write_cmd(input cmd_t c);
    host    = c;
    HOST_WR = 1'b1;
    step();
    HOST_WR = 1'b0;
  endtask

  // Sequencer accepts the loaded command and returns to its start state.
  task automatic release_seq();
    REQ_COMMAND = 1'b1;
    step();
    REQ_COMMAND = 1'b0;
    step();
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (WR_DATA !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(WR_DATA), 64'd1);
  endtask

  initial begin
    cmd_t c, c5;
    cmd_t ov[$];
    int   base, writes, n_stale;
    logic [63:0] ts;

    // Reset values
    step(); step();
    chk("rst_wr_data", 64'(WR_DATA), 64'd0);
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_empty", 64'(EMPTY), 64'd1);
    chk("rst_full", 64'(FULL), 64'd0);
    chk("rst_loaded", 64'(LOADED), 64'd0);
    chk("rst_overflow", 64'(OVERFLOW), 64'd0);
    chk("rst_dropped", 64'(DROPPED), 64'd0);
    chk_cmd("rst_mem", mem_obs, '0);
    RESET = 1'b0;
    step();

    // Single command latency
    c = rand_cmd(tnow + 64'd1000);
    c.freq = 48'h123456789ABC;
    exp_q.push_back(c);
    write_cmd(c);
    chk("t1_count_after_t", 64'(COUNT), 64'd1);
    chk("t1_wr_t", 64'(WR_DATA), 64'd0);
    step();
    chk("t1_wr_t1", 64'(WR_DATA), 64'd0);
    step();
    chk("t1_wr_t2", 64'(WR_DATA), 64'd1);
    chk("t1_freq", 64'(m_freq), 64'h123456789ABC);
    chk_cmd("t1_mem", mem_obs, c);
    chk("t1_loaded", 64'(LOADED), 64'd1);
    chk("t1_count", 64'(COUNT), 64'd0);
    step();
    chk("t1_wr_t3", 64'(WR_DATA), 64'd0);
    REQ_COMMAND = 1'b1;
    step();
    chk("t1_loaded_clr", 64'(LOADED), 64'd0);
    REQ_COMMAND = 1'b0;
    step();

    // Three queued, one delivered per sequencer handshake
    base = strobes;
    for (int i = 0; i < 3; i++) begin
      c = rand_cmd(tnow + 64'd5000 + 64'(i));
      exp_q.push_back(c);
      ov.push_back(c);
      write_cmd(c);
    end
    repeat (6) step();
    chk("t2_one_strobe", 64'(strobes - base), 64'd1);
    chk("t2_count", 64'(COUNT), 64'd2);
    REQ_COMMAND = 1'b1;
    step();
    chk("t2_loaded_clr", 64'(LOADED), 64'd0);
    repeat (5) step();
    chk("t2_no_strobe_req_high", 64'(strobes - base), 64'd1);
    REQ_COMMAND = 1'b0;
    step();
    chk("t2_wr_d0", 64'(WR_DATA), 64'd0);
    step();
    chk("t2_wr_d1", 64'(WR_DATA), 64'd1);
    chk_cmd("t2_second", mem_obs, ov[1]);
    release_seq();
    wait_strobe("t2_third_strobe");
    chk_cmd("t2_third", mem_obs, ov[2]);
    release_seq();
    ov.delete();

    // Stale head dropped, following command delivered
    base = strobes;
    c = rand_cmd(tnow + 64'd10);
    write_cmd(c);
    c = rand_cmd(tnow + 64'd2000);
    exp_q.push_back(c);
    write_cmd(c);
    step();
    chk("t3_dropped", 64'(DROPPED), 64'd1);
    step();
    step();
    chk("t3_wr", 64'(WR_DATA), 64'd1);
    chk_cmd("t3_mem", mem_obs, c);
    step();
    chk("t3_strobes", 64'(strobes - base), 64'd1);
    release_seq();

    // Overflow with delivery held off
    REQ_COMMAND = 1'b1;
    step();
    base = strobes;
    for (int i = 0; i <= DEPTH; i++) begin
      c = rand_cmd(tnow + 64'd10000 + 64'(i));
      if (i < DEPTH) exp_q.push_back(c);
      write_cmd(c);
    end
    chk("t4_full", 64'(FULL), 64'd1);
    chk("t4_count", 64'(COUNT), 64'(DEPTH));
    chk("t4_overflow", 64'(OVERFLOW), 64'd1);
    chk("t4_empty", 64'(EMPTY), 64'd0);
    REQ_COMMAND = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_strobe("t4_drain");
      release_seq();
    end
    repeat (10) step();
    chk("t4_strobes", 64'(strobes - base), 64'(DEPTH));
    chk("t4_empty_after", 64'(EMPTY), 64'd1);

    // Flush with a same-cycle write on a queue of 5
    c5 = rand_cmd(tnow + 64'd3000);
    exp_q.push_back(c5);
    write_cmd(c5);
    wait_strobe("t5_first");
    step();
    for (int i = 0; i < 5; i++) write_cmd(rand_cmd(tnow + 64'd4000));
    chk("t5_count5", 64'(COUNT), 64'd5);
    base = strobes;
    host    = rand_cmd(tnow + 64'd4000);
    HOST_WR = 1'b1;
    FLUSH   = 1'b1;
    step();
    HOST_WR = 1'b0;
    FLUSH   = 1'b0;
    chk("t5_count0", 64'(COUNT), 64'd0);
    chk("t5_empty", 64'(EMPTY), 64'd1);
    chk("t5_loaded", 64'(LOADED), 64'd1);
    chk_cmd("t5_mem_kept", mem_obs, c5);
    chk("t5_overflow_kept", 64'(OVERFLOW), 64'd1);
    release_seq();
    repeat (10) step();
    chk("t5_no_strobe", 64'(strobes - base), 64'd0);

    // Asynchronous reset while in CHECK with 4 queued
    REQ_COMMAND = 1'b1;
    step();
    for (int i = 0; i < 4; i++) write_cmd(rand_cmd(tnow + 64'd6000));
    chk("t6_count4", 64'(COUNT), 64'd4);
    base = strobes;
    REQ_COMMAND = 1'b0;
    step();
    #1 RESET = 1'b1;
    #1;
    chk("t6_count", 64'(COUNT), 64'd0);
    chk("t6_empty", 64'(EMPTY), 64'd1);
    chk("t6_loaded", 64'(LOADED), 64'd0);
    chk("t6_overflow", 64'(OVERFLOW), 64'd0);
    chk("t6_dropped", 64'(DROPPED), 64'd0);
    chk_cmd("t6_mem", mem_obs, '0);
    step(); step();
    RESET = 1'b0;
    repeat (10) step();
    chk("t6_no_strobe", 64'(strobes - base), 64'd0);

    // Randomized traffic: deliveries must be the fresh commands in write order
    writes  = 0;
    n_stale = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      HOST_WR = 1'b0;
      if (writes < 12 && cyc < 400 && $urandom_range(3) == 0) begin
        case ($urandom_range(4))
          0:       ts = tnow + 64'(LEAD) - 64'd1;
          1:       ts = tnow + 64'(LEAD);
          2:       ts = tnow + 64'($urandom_range(47));
          3:       ts = tnow + 64'(LEAD) + 64'($urandom_range(100000));
          default: ts = tnow - 64'($urandom_range(1000));
        endcase
        c = rand_cmd(ts);
        if (ts < tnow + 64'(LEAD)) n_stale++;
        else exp_q.push_back(c);
        host    = c;
        HOST_WR = 1'b1;
        writes++;
      end
      if (!REQ_COMMAND && LOADED && $urandom_range(2) == 0) REQ_COMMAND = 1'b1;
      else if (REQ_COMMAND && $urandom_range(2) == 0) REQ_COMMAND = 1'b0;
      step();
    end
    HOST_WR = 1'b0;
    chk("rnd_dropped", 64'(DROPPED), 64'(n_stale));
    chk("rnd_overflow", 64'(OVERFLOW), 64'd0);
    chk("rnd_empty", 64'(EMPTY), 64'd1);

    chk("deliveries", 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) chk_cmd("delivered", cap_q[i], exp_q[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
